// File: rtl/ham_sched_pkg.sv
// rtl/ham_sched_pkg.sv - shared FSM states, op encodings and defaults for ham_sched
package ham_sched_pkg;

   localparam int CNT_W_DEF = 16;

   localparam logic OP_POP = 1'b0;
   localparam logic OP_HAM = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   function automatic logic [31:0] sel_operand(input logic op, input logic [31:0] a,
                                               input logic [31:0] b);
      return (op == OP_HAM) ? (a ^ b) : a;
   endfunction

endpackage

// File: rtl/ham_32bit.sv
// rtl/ham_32bit.sv - combinational 32-bit population count, 6-bit result
module ham_32bit (
   input  logic [31:0] din,
   output logic [5:0]  cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < 32; i++) begin
         cnt = cnt + {5'd0, din[i]};
      end
   end

endmodule

// File: rtl/ham_sched.sv
// rtl/ham_sched.sv - two-requester round-robin popcount/Hamming burst accumulator
module ham_sched
   import ham_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic             req0_op,
   input  logic             req0_last,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic             req1_op,
   input  logic             req1_last,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [CNT_W-1:0] resp_count
);

   state_e             state_q, state_d;
   logic               owner_q, owner_d;
   logic               ptr_q, ptr_d;
   logic [1:0]         rdy_q, rdy_d;
   logic [1:0]         rvld_q, rvld_d;
   logic [31:0]        opnd_q, opnd_d;
   logic               opnd_vld_q, opnd_vld_d;
   logic [CNT_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [5:0]         pop;
   logic [CNT_W-1:0]   pop_ext;
   logic [CNT_W:0]     sum;
   logic               in_valid, in_op, in_last, grant, rsp_rdy;
   logic [31:0]        in_a, in_b;

   ham_32bit u_pop (
      .din (opnd_q),
      .cnt (pop)
   );

   always_comb begin
      in_valid = owner_q ? req1_valid : req0_valid;
      in_a     = owner_q ? req1_a     : req0_a;
      in_b     = owner_q ? req1_b     : req0_b;
      in_op    = owner_q ? req1_op    : req0_op;
      in_last  = owner_q ? req1_last  : req0_last;
      rsp_rdy  = owner_q ? resp1_ready : resp0_ready;
      pop_ext  = CNT_W'(pop);
      sum      = {1'b0, acc_q} + {1'b0, pop_ext};
      grant    = 1'b0;

      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      rdy_d      = rdy_q;
      rvld_d     = rvld_q;
      opnd_d     = opnd_q;
      opnd_vld_d = 1'b0;
      acc_d      = acc_q;
      count_d    = count_q;

      // Operand registered last cycle is folded in now; carry-out pins at all-ones.
      if (opnd_vld_q) begin
         acc_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end

      case (state_q)
         ST_IDLE: begin
            if (req0_valid || req1_valid) begin
               grant   = (req0_valid && req1_valid) ? ptr_q : req1_valid;
               owner_d = grant;
               rdy_d   = grant ? 2'b10 : 2'b01;
               acc_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (in_valid) begin
               opnd_d     = sel_operand(in_op, in_a, in_b);
               opnd_vld_d = 1'b1;
               if (in_last) begin
                  rdy_d   = 2'b00;
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rvld_q == 2'b00) begin
               rvld_d  = owner_q ? 2'b10 : 2'b01;
               count_d = acc_q;
            end else if (rsp_rdy) begin
               rvld_d  = 2'b00;
               ptr_d   = ~owner_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= 1'b0;
         ptr_q      <= 1'b0;
         rdy_q      <= 2'b00;
         rvld_q     <= 2'b00;
         opnd_q     <= '0;
         opnd_vld_q <= 1'b0;
         acc_q      <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         rdy_q      <= rdy_d;
         rvld_q     <= rvld_d;
         opnd_q     <= opnd_d;
         opnd_vld_q <= opnd_vld_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
      end
   end

   assign req0_ready  = rdy_q[0];
   assign req1_ready  = rdy_q[1];
   assign resp0_valid = rvld_q[0];
   assign resp1_valid = rvld_q[1];
   assign resp_count  = count_q;

endmodule

// File: tb/tb_ham_sched.sv
// tb/tb_ham_sched.sv - directed self-checking bench for ham_sched
module tb_ham_sched;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req0_ready, req0_op, req0_last;
   logic             req1_valid, req1_ready, req1_op, req1_last;
   logic [31:0]      req0_a, req0_b, req1_a, req1_b;
   logic             resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic [CNT_W-1:0] resp_count;

   ham_sched #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_op     (req0_op),
      .req0_last   (req0_last),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_op     (req1_op),
      .req1_last   (req1_last),
      .resp0_valid (resp0_valid),
      .resp0_ready (resp0_ready),
      .resp1_valid (resp1_valid),
      .resp1_ready (resp1_ready),
      .resp_count  (resp_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] ba [0:2047];
   logic [31:0] bb [0:2047];
   logic        bo [0:2047];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int n, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic op, input logic last);
      if (n == 0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_last = last;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_last = last;
      end
   endtask

   task automatic set_beat(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic op);
      ba[i] = a; bb[i] = b; bo[i] = op;
   endtask

   function automatic logic rdy(input int n);
      return (n == 0) ? req0_ready : req1_ready;
   endfunction

   function automatic logic rvld(input int n);
      return (n == 0) ? resp0_valid : resp1_valid;
   endfunction

   task automatic set_rsp_ready(input int n, input logic v);
      if (n == 0) resp0_ready = v;
      else        resp1_ready = v;
   endtask

   function automatic logic [31:0] outs_vec();
      return 32'({req0_ready, req1_ready, resp0_valid, resp1_valid, resp_count});
   endfunction

   // Drives one burst on requester n, then checks latency, result, isolation and handshake.
   task automatic burst(input string tag, input int n, input int nb, input int gap_at,
                        input int hold, input logic [31:0] exp);
      int   i = 0;
      int   guard = 0;
      int   lat = 0;
      logic take;
      logic gapped = 1'b0;
      logic other_rdy = 1'b0;
      logic [CNT_W-1:0] held;
      while (i < nb && guard < nb + 50) begin
         if (i == gap_at && !gapped) begin
            set_req(n, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
            repeat (3) begin
               other_rdy = other_rdy | rdy(1 - n);
               tick;
            end
            chk({tag, "_gap_ready"}, 32'(rdy(n)), 32'd1);
            gapped = 1'b1;
         end
         set_req(n, 1'b1, ba[i], bb[i], bo[i], (i == nb - 1));
         take      = rdy(n);
         other_rdy = other_rdy | rdy(1 - n);
         tick;
         guard++;
         if (take) i++;
      end
      chk({tag, "_beats"}, 32'(i), 32'(nb));
      set_req(n, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      while (!rvld(n) && lat < 20) begin
         other_rdy = other_rdy | rdy(1 - n);
         tick;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd2);
      chk({tag, "_count"}, 32'(resp_count), exp);
      chk({tag, "_other_ready"}, 32'(other_rdy), 32'd0);
      chk({tag, "_other_resp"}, 32'(rvld(1 - n)), 32'd0);
      held = resp_count;
      for (int k = 0; k < hold; k++) begin
         tick;
         chk({tag, "_hold_count"}, 32'(resp_count), 32'(held));
         chk({tag, "_hold_valid"}, 32'(rvld(n)), 32'd1);
         chk({tag, "_hold_nogrant"}, 32'({req0_ready, req1_ready}), 32'd0);
      end
      set_rsp_ready(n, 1'b1);
      tick;
      chk({tag, "_resp_done"}, 32'(rvld(n)), 32'd0);
      set_rsp_ready(n, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
      #3;
      chk("reset_outputs", outs_vec(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      chk("idle_outputs", outs_vec(), 32'd0);

      // Contention straight after reset: requester 0 owns the pointer.
      set_req(1, 1'b1, 32'h0000_0003, 32'h0, 1'b0, 1'b1);
      set_beat(0, 32'hFFFF_FFFF, 32'h0, 1'b0);
      burst("single_r0", 0, 1, -1, 0, 32'd32);

      set_req(0, 1'b1, 32'h0000_00FF, 32'h0, 1'b0, 1'b1);
      set_beat(0, 32'h0000_000F, 32'h0, 1'b0);
      set_beat(1, 32'hF0F0_F0F0, 32'h0, 1'b0);
      burst("burst_r1", 1, 2, -1, 0, 32'd20);

      set_req(1, 1'b1, 32'h0000_0007, 32'h0, 1'b0, 1'b1);
      set_beat(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
      burst("ham_bp_r0", 0, 1, -1, 5, 32'd32);

      set_beat(0, 32'h0000_0007, 32'h0, 1'b0);
      burst("pop7_r1", 1, 1, -1, 0, 32'd3);

      set_beat(0, 32'h1234_5678, 32'h1234_5678, 1'b1);
      burst("ham_zero_r0", 0, 1, -1, 0, 32'd0);

      set_beat(0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
      set_beat(1, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b1);
      burst("mixed_gap_r1", 1, 2, 1, 0, 32'd17);

      for (int i = 0; i < 2048; i++) set_beat(i, 32'hFFFF_FFFF, 32'h0, 1'b0);
      burst("saturate_r0", 0, 2048, -1, 0, 32'hFFFF);

      // Abort mid-burst after two accepted beats.
      set_req(0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
      tick;
      chk("abort_granted", 32'(req0_ready), 32'd1);
      tick;
      tick;
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", outs_vec(), 32'd0);
      set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         logic seen = 1'b0;
         for (int k = 0; k < 6; k++) begin
            tick;
            seen = seen | resp0_valid | resp1_valid;
         end
         chk("abort_no_resp", 32'(seen), 32'd0);
      end
      set_beat(0, 32'h0F0F_0F0F, 32'h0, 1'b0);
      burst("fresh_r0", 0, 1, -1, 0, 32'd16);

      // Abort while a response is pending.
      set_req(1, 1'b1, 32'h0000_FFFF, 32'h0, 1'b0, 1'b1);
      tick;
      tick;
      set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick;
      tick;
      chk("resp_pending", 32'(resp1_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("resp_abort_outputs", outs_vec(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         logic seen = 1'b0;
         for (int k = 0; k < 4; k++) begin
            tick;
            seen = seen | resp0_valid | resp1_valid;
         end
         chk("resp_abort_no_resp", 32'(seen), 32'd0);
      end
      set_beat(0, 32'h8000_0001, 32'h0, 1'b0);
      burst("after_abort_r1", 1, 1, -1, 0, 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ham_sched.md
HAM_SCHED -- requirements
Module: ham_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning accumulator/result width in bits (minimum 6).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) beat valid.
REQ-005 SHALL have ports reqN_ready  output  1  beat accepted when valid and ready are both high.
REQ-006 SHALL have ports reqN_a, reqN_b  input  32 each  operand words.
REQ-007 SHALL have ports reqN_op  input  1  0 = popcount(a); 1 = Hamming distance popcount(a XOR b); sampled per beat.
REQ-008 SHALL have ports reqN_last  input  1  marks final beat of a burst.
REQ-009 SHALL have ports respN_valid  output  1, and respN_ready  input  1  per-requester response handshake.
REQ-010 SHALL have port resp_count  output  CNT_W  shared result bus, meaningful only while a respN_valid is high.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DRAIN, RESP.
REQ-012 IDLE: if any reqN_valid, grant one requester, clear accumulator, go to BUSY; reqN_ready low in IDLE.
REQ-013 Arbitration: round-robin; on simultaneous requests the priority-pointer requester wins; pointer moves to the other requester on each completed response handshake.
REQ-014 BUSY: only the granted requester's ready is high, every cycle (one beat per cycle); the other requester's ready is low.
REQ-015 Accepted beat: selected operand (a, or a XOR b) registered at edge t; its popcount added to accumulator at edge t+1.
REQ-016 Valid dropped mid-burst: no accumulation that cycle; stay in BUSY indefinitely, no timeout.
REQ-017 Last beat accepted in BUSY -> DRAIN for exactly one cycle -> RESP; owner's respN_valid high from edge t+2 after last-beat edge t.
REQ-018 Single-beat burst (last on first beat) SHALL behave identically to REQ-017.
REQ-019 Accumulation SHALL saturate at 2^CNT_W-1, never wrap.
REQ-020 RESP: respN_valid and resp_count held stable until respN_ready; no new grant while in RESP.
REQ-021 Response handshake -> IDLE; new grant earliest on the following cycle.
REQ-022 Non-owner respN_valid SHALL be low at all times.

Reset
REQ-023 Asserting rst_n low SHALL immediately force state IDLE; all ready/valid outputs low; resp_count, accumulator and operand register zero; priority pointer set to requester 0.
REQ-024 Reset mid-burst or during RESP SHALL abort the operation with no response issued.
REQ-025 Reset deassertion SHALL need no further initialisation; grants may begin on the first edge after release.

Structure
REQ-026 SHALL instantiate the existing ham_32bit popcount unit once as the sole counting resource (6-bit result, zero-extended to CNT_W).
REQ-027 FSM state encoding, op encodings (OP_POP, OP_HAM), and default CNT_W SHALL live in the shared processor package.
REQ-028 Arbiter SHALL be inline logic, not a separate sub-module.

Verification
REQ-029 Single beat: req0 a=0xFFFFFFFF, op=0, last=1 -> resp0_valid 2 cycles after acceptance, resp_count=32.
REQ-030 Burst: req1 beats a=0x0000000F then 0xF0F0F0F0 (last), op=0 -> resp_count=20; req0_ready low throughout.
REQ-031 Hamming: a=0xAAAAAAAA, b=0x55555555, op=1 -> 32; a=b=0x12345678 -> 0.
REQ-032 Contention: both valid in same IDLE cycle after reset -> req0 granted first, req1 next; repeat -> req1 first.
REQ-033 Backpressure: hold resp0_ready low 5 cycles -> resp_count stable, no grant to req1 until handshake.
REQ-034 Reset mid-burst (after 2 beats) -> all outputs zero, no respN_valid; next fresh burst returns correct count.
